fifo_alu_sequencer: RTL and testbench

Sequences the UART-to-ALU datapath. It pops operand A, operand B and an opcode from the receive FIFO, presents them to the combinational ALU, and captures the result. It then pushes the result into the transmit FIFO. It sits between the RX FIFO read port, the ALU and the TX FIFO write port. Partial frames are abandoned after a configurable idle timeout.

---
 rtl/fifo_alu_sequencer_if.sv | 29 ++
 rtl/fifo_alu_sequencer.sv | 85 ++++++++
 tb/tb_fifo_alu_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_alu_sequencer_if.sv
// RX-FIFO read port, TX-FIFO write port and ALU operand/result bundle seen by
// the sequencer; master is the sequencer side, slave is the FIFO/ALU side.
interface fifo_alu_sequencer_if #(
  parameter int B    = 8,
  parameter int OP_W = 6
);
  logic            i_rx_empty;
  logic [B-1:0]    i_rx_data;
  logic            o_rx_rd;
  logic            i_tx_full;
  logic            o_tx_wr;
  logic [B-1:0]    o_tx_data;
  logic [B-1:0]    o_alu_a;
  logic [B-1:0]    o_alu_b;
  logic [OP_W-1:0] o_alu_op;
  logic [B-1:0]    i_alu_result;
  logic            o_busy;
  logic            o_timeout;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full, i_alu_result,
    output o_rx_rd, o_tx_wr, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_timeout
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full, i_alu_result,
    input  o_rx_rd, o_tx_wr, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_timeout
  );
endinterface

// File: rtl/fifo_alu_sequencer.sv
// Pops A, B, OP from the RX FIFO, gives the ALU one cycle, pushes the result to
// the TX FIFO. Partial frames are dropped after TIMEOUT empty cycles.
module fifo_alu_sequencer #(
  parameter int B       = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 1000
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fifo_alu_sequencer_if.master bus
);
  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, PUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [B-1:0]    a_q, b_q, res_q;
  logic [OP_W-1:0] op_q;
  logic            to_q;
  logic            in_get, rx_rd, tx_wr, to_hit;

  assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_OP);
  assign rx_rd  = in_get && !bus.i_rx_empty && !i_reset;
  assign tx_wr  = (state == PUSH) && !bus.i_tx_full && !i_reset;
  // Only the B/OP waits can time out; a word present on the last cycle wins.
  assign to_hit = ((state == GET_B) || (state == GET_OP)) && bus.i_rx_empty && (cnt == TO_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= GET_A;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= to_hit;
      case (state)
        GET_A: if (rx_rd) begin
          a_q   <= bus.i_rx_data;
          cnt   <= '0;
          state <= GET_B;
        end
        GET_B: if (rx_rd) begin
          b_q   <= bus.i_rx_data;
          cnt   <= '0;
          state <= GET_OP;
        end else if (to_hit) begin
          cnt   <= '0;
          state <= GET_A;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GET_OP: if (rx_rd) begin
          op_q  <= bus.i_rx_data[OP_W-1:0];
          cnt   <= '0;
          state <= EXEC;
        end else if (to_hit) begin
          cnt   <= '0;
          state <= GET_A;
        end else begin
          cnt <= cnt + 1'b1;
        end
        EXEC: begin
          res_q <= bus.i_alu_result;
          state <= PUSH;
        end
        PUSH: if (tx_wr) state <= GET_A;
        default: state <= GET_A;
      endcase
    end
  end

  assign bus.o_rx_rd   = rx_rd;
  assign bus.o_tx_wr   = tx_wr;
  assign bus.o_tx_data = res_q;
  assign bus.o_alu_a   = a_q;
  assign bus.o_alu_b   = b_q;
  assign bus.o_alu_op  = op_q;
  assign bus.o_busy    = (state != GET_A);
  assign bus.o_timeout = to_q;
endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// Randomised scoreboard bench: a frame-level model predicts pops, pushes,
// busy and timeouts; a monitor compares them against the sequencer each cycle.
module tb_fifo_alu_sequencer;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_alu_sequencer_if #(.B(8), .OP_W(6)) bus ();

  fifo_alu_sequencer #(.B(8), .OP_W(6), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  function automatic logic [7:0] alu(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    return (op == 6'h22) ? a - b : a + b;
  endfunction
  assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_pop = 0, n_push = 0, n_to = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_res[$];
  int wr_cyc[$], to_cyc[$];
  logic rst_ctl, gate, full_ctl, mon_en = 1'b0;
  logic exp_rd, exp_wr, exp_busy, exp_to;

  // frame-level reference: words collected so far, exec/push phase, idle run
  int ph = 0, nw = 0, idle = 0;
  logic to_flag = 1'b0;
  logic [7:0] fw[3];
  logic [7:0] junk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic step();
    rst            = rst_ctl;
    bus.i_rx_empty = gate || (rxq.size() == 0);
    bus.i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
    bus.i_tx_full  = full_ctl;
    #1;
    exp_busy = !(ph == 0 && nw == 0);
    exp_to   = to_flag;
    to_flag  = 1'b0;
    exp_rd   = 1'b0;
    exp_wr   = 1'b0;
    if (rst_ctl) begin
      ph = 0; nw = 0; idle = 0;
    end else if (ph == 0) begin
      if (!bus.i_rx_empty) begin
        exp_rd = 1'b1;
        fw[nw] = bus.i_rx_data;
        nw++;
        idle = 0;
        if (nw == 3) begin
          exp_res.push_back(alu(fw[0], fw[1], fw[2][5:0]));
          ph = 1; nw = 0;
        end
      end else if (nw > 0) begin
        idle++;
        if (idle == TO) begin
          to_flag = 1'b1; nw = 0; idle = 0;
        end
      end
    end else if (ph == 1) begin
      ph = 2;
    end else if (!full_ctl) begin
      exp_wr = 1'b1;
      ph = 0;
    end
    if (bus.o_rx_rd && rxq.size() != 0) junk = rxq.pop_front();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_alu_a"},   bus.o_alu_a,   0);
    chk({tag, "_alu_b"},   bus.o_alu_b,   0);
    chk({tag, "_alu_op"},  bus.o_alu_op,  0);
    chk({tag, "_tx_data"}, bus.o_tx_data, 0);
    chk({tag, "_busy"},    bus.o_busy,    0);
    chk({tag, "_timeout"}, bus.o_timeout, 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("rx_rd",   bus.o_rx_rd,   exp_rd);
      chk("tx_wr",   bus.o_tx_wr,   exp_wr);
      chk("busy",    bus.o_busy,    exp_busy);
      chk("timeout", bus.o_timeout, exp_to);
      chk("rd_wr_excl", bus.o_rx_rd & bus.o_tx_wr, 0);
      if (bus.o_rx_rd) n_pop++;
      if (bus.o_timeout) begin n_to++; to_cyc.push_back(cyc); end
      if (bus.o_tx_wr) begin
        n_push++;
        wr_cyc.push_back(cyc);
        if (exp_res.size() == 0) chk("tx_data_unexpected", 1, 0);
        else chk("tx_data", bus.o_tx_data, exp_res.pop_front());
      end
    end
  end

  initial begin
    int t0, p0, w0, k0, o0;
    rst_ctl = 1'b1; gate = 1'b0; full_ctl = 1'b0; rst = 1'b1;
    bus.i_rx_empty = 1'b1; bus.i_rx_data = '0; bus.i_tx_full = 1'b0;
    @(negedge clk);
    step();
    mon_en = 1'b1;
    step();
    rst_ctl = 1'b0;
    chk_reset_vals("reset");

    // back-to-back frames
    t0 = cyc; p0 = n_pop; w0 = n_push; k0 = wr_cyc.size();
    rxq = '{8'h05, 8'h03, 8'h20, 8'h0A, 8'h01, 8'h22};
    run(12);
    chk("b2b_pops", n_pop - p0, 6);
    chk("b2b_pushes", n_push - w0, 2);
    if (wr_cyc.size() >= k0 + 2) begin
      chk("b2b_push0_cycle", wr_cyc[k0] - t0, 4);
      chk("b2b_push1_cycle", wr_cyc[k0+1] - t0, 9);
    end else chk("b2b_push_count", wr_cyc.size() - k0, 2);

    // TX back-pressure for 20 cycles of PUSH
    p0 = n_pop; w0 = n_push; full_ctl = 1'b1;
    rxq = '{8'h40, 8'h15, 8'h22, 8'h01, 8'h02, 8'h20};
    run(24);
    chk("bp_pops_stalled", n_pop - p0, 3);
    chk("bp_no_push", n_push - w0, 0);
    chk("bp_busy", bus.o_busy, 1);
    full_ctl = 1'b0;
    step();
    chk("bp_release_push", n_push - w0, 1);
    run(8);
    chk("bp_pops_total", n_pop - p0, 6);
    chk("bp_push_total", n_push - w0, 2);

    // timeout after lone A
    t0 = cyc; o0 = n_to; w0 = n_push;
    rxq.push_back(8'h11);
    run(12);
    chk("to_count", n_to - o0, 1);
    if (to_cyc.size() != 0) chk("to_cycle", to_cyc[$] - t0, 9);
    chk("to_idle", bus.o_busy, 0);
    rxq = '{8'h30, 8'h0F, 8'h22};
    run(6);
    chk("to_next_frame", n_push - w0, 1);

    // B arrives on the last tolerated cycle
    o0 = n_to; w0 = n_push; p0 = n_pop;
    rxq.push_back(8'h50);
    run(8);
    rxq.push_back(8'h06);
    step();
    rxq.push_back(8'h20);
    run(6);
    chk("bnd_no_timeout", n_to - o0, 0);
    chk("bnd_pops", n_pop - p0, 3);
    chk("bnd_push", n_push - w0, 1);

    // reset while waiting in GET_OP
    w0 = n_push;
    rxq = '{8'h09, 8'h01, 8'h22};
    run(2);
    rst_ctl = 1'b1;
    step();
    rst_ctl = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_no_push", n_push - w0, 0);
    rxq.push_back(8'h04);
    rxq.push_back(8'h20);
    run(8);
    chk("midrst_fresh_frame", n_push - w0, 1);

    // sparse RX, one word every 3 cycles
    o0 = n_to; w0 = n_push;
    for (int i = 0; i < 9; i++)
      rxq.push_back((i % 3 == 2) ? (($urandom_range(0, 1) != 0) ? 8'h22 : 8'h20) : 8'($urandom));
    for (int i = 0; i < 30; i++) begin
      gate = ((i % 3) != 0);
      step();
    end
    gate = 1'b0;
    chk("sparse_no_timeout", n_to - o0, 0);
    chk("sparse_pushes", n_push - w0, 3);

    // random traffic with back-pressure and occasional long silences
    for (int i = 0; i < 600; i++) begin
      if (rxq.size() < 8 && $urandom_range(0, 2) == 0) rxq.push_back(8'($urandom));
      gate     = ((i % 100) >= 85) || ($urandom_range(0, 9) < 3);
      full_ctl = ($urandom_range(0, 9) < 3);
      step();
    end
    gate = 1'b0; full_ctl = 1'b0;
    run(30);
    chk("drain_scoreboard", exp_res.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
